spm_loader: RTL

SPM_LOADER -- requirements
Module: spm_loader

---
 rtl/spm_loader_if.sv | 26 ++
 rtl/spm_loader.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/spm_loader_if.sv
// Image-load stream and SRAM write port between the loader and its environment.
// The loader takes the slave modport; the image source/SRAM side takes master.
interface spm_loader_if #(
  parameter int WORD_SIZE = 8,
  parameter int ADDR_SIZE = 8
);
  logic                 ld_valid;
  logic                 ld_ready;
  logic [ADDR_SIZE-1:0] ld_addr;
  logic [WORD_SIZE-1:0] ld_data;
  logic                 ld_last;

  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;

  modport master (
    output ld_valid, ld_addr, ld_data, ld_last,
    input  ld_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data, ld_last,
    output ld_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/spm_loader.sv
// RISC_SPM program loader and run supervisor: optional zero-fill, image load, supervised run.
// Define SPM_LOADER_CLEAR_EN to compile in the CLEAR zero-fill pass ahead of LOAD.
module spm_loader #(
  parameter int WORD_SIZE      = 8,
  parameter int ADDR_SIZE      = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  spm_loader_if.slave bus,
  output logic        cpu_rst_n,
  input  logic        cpu_halt,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] run_cycles
);

  localparam logic [15:0] RUN_LIMIT = 16'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
`ifdef SPM_LOADER_CLEAR_EN
    CLEAR  = 3'd1,
`endif
    LOAD   = 3'd2,
    RUN    = 3'd3,
    HALTED = 3'd4,
    ABORT  = 3'd5
  } state_t;

`ifdef SPM_LOADER_CLEAR_EN
  localparam state_t FIRST_STATE = CLEAR;
  logic [ADDR_SIZE-1:0] clr_addr_q;
`else
  localparam state_t FIRST_STATE = LOAD;
`endif

  state_t      state_q;
  state_t      state_d;
  logic [15:0] run_q;
  logic [15:0] run_inc;
  logic        limit_hit;
  logic        launch;

  // HALTED and ABORT accept start exactly like IDLE.
  assign launch    = start && (state_q inside {IDLE, HALTED, ABORT});
  assign run_inc   = (run_q == 16'hFFFF) ? run_q : run_q + 16'd1;
  assign limit_hit = (run_inc == RUN_LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The count includes the cycle in which halt or the limit is seen, then freezes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= 16'd0;
    end else if (state_q == RUN) begin
      run_q <= run_inc;
    end else if (launch) begin
      run_q <= 16'd0;
    end
  end

`ifdef SPM_LOADER_CLEAR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_addr_q <= '0;
    end else if (state_q == CLEAR) begin
      clr_addr_q <= clr_addr_q + ADDR_SIZE'(1);
    end else begin
      clr_addr_q <= '0;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HALTED, ABORT: begin
        if (start) state_d = FIRST_STATE;
      end
`ifdef SPM_LOADER_CLEAR_EN
      CLEAR: begin
        if (clr_addr_q == {ADDR_SIZE{1'b1}}) state_d = LOAD;
      end
`endif
      LOAD: begin
        if (bus.ld_valid && bus.ld_last) state_d = RUN;
      end
      RUN: begin
        // Halt wins over a simultaneous limit hit.
        if (cpu_halt) begin
          state_d = HALTED;
        end else if (limit_hit) begin
          state_d = ABORT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    bus.ld_ready  = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {ADDR_SIZE{1'b0}};
    bus.mem_wdata = {WORD_SIZE{1'b0}};
    cpu_rst_n     = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    timeout       = 1'b0;
    case (state_q)
`ifdef SPM_LOADER_CLEAR_EN
      CLEAR: begin
        busy         = 1'b1;
        bus.mem_we   = 1'b1;
        bus.mem_addr = clr_addr_q;
      end
`endif
      LOAD: begin
        busy         = 1'b1;
        bus.ld_ready = 1'b1;
        // Accepted words pass straight through to the SRAM in the same cycle.
        if (bus.ld_valid) begin
          bus.mem_we    = 1'b1;
          bus.mem_addr  = bus.ld_addr;
          bus.mem_wdata = bus.ld_data;
        end
      end
      RUN: begin
        busy      = 1'b1;
        cpu_rst_n = 1'b1;
      end
      HALTED:  done    = 1'b1;
      ABORT:   timeout = 1'b1;
      default: ;
    endcase
  end

  assign run_cycles = run_q;

endmodule
